// File: rtl/core_pkg.sv
// Shared definitions for the core_v1 multi-cycle sequencer: opcodes, state
// encoding, instruction classes and per-class control properties.
package core_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  typedef enum logic [3:0] {
    CLS_LOAD, CLS_STORE, CLS_OP, CLS_OPIMM, CLS_BRANCH,
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } cls_e;

  // Per-class property masks, bit index = cls_e value.
  localparam logic [9:0] CLS_REG_WE = 10'b01_1110_1101;
  localparam logic [9:0] CLS_MEM    = 10'b00_0000_0011;
  localparam logic [9:0] CLS_JUMP   = 10'b01_1000_0000;

  function automatic logic cls_bit(input logic [9:0] mask, input cls_e c);
    return mask[c];
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> instruction class mapping; flags anything unsupported.
module opcode_classifier
  import core_pkg::*;
(
  input  logic [6:0] i_opcode,
  output cls_e       o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls = CLS_ILLEGAL;
    case (i_opcode)
      OPC_LOAD:   o_cls = CLS_LOAD;
      OPC_STORE:  o_cls = CLS_STORE;
      OPC_OP:     o_cls = CLS_OP;
      OPC_OPIMM:  o_cls = CLS_OPIMM;
      OPC_BRANCH: o_cls = CLS_BRANCH;
      OPC_LUI:    o_cls = CLS_LUI;
      OPC_AUIPC:  o_cls = CLS_AUIPC;
      OPC_JAL:    o_cls = CLS_JAL;
      OPC_JALR:   o_cls = CLS_JALR;
      default:    o_cls = CLS_ILLEGAL;
    endcase
  end

  assign o_illegal = (o_cls == CLS_ILLEGAL);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for core_v1: fetch/decode/exec/mem/wb sequencing,
// memory handshakes with timeout, write-enable gating and retire counting.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  input  logic             i_imem_ready,
  input  logic             i_dmem_ready,
  output logic             o_imem_req,
  output logic             o_ir_w_en,
  output logic             o_dmem_req,
  output logic             o_dmem_w_en,
  output logic             o_reg_w_en,
  output logic             o_pc_w_en,
  output logic             o_pc_sel,
  output logic             o_illegal,
  output logic             o_bus_err,
  output logic [CNT_W-1:0] o_instret,
  output logic [2:0]       o_state
);

  localparam int               WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic             TMO_EN    = (TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]        r_state, w_state_nxt;
  cls_e              r_cls, w_dec_cls;
  logic              w_dec_illegal;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;
  logic              r_illegal, r_bus_err;
  logic              w_in_fetch, w_in_mem, w_in_wb, w_ready, w_waiting, w_expired, w_live;

  opcode_classifier u_cls (
    .i_opcode  (i_opcode),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal)
  );

  assign w_in_fetch = (r_state == ST_FETCH);
  assign w_in_mem   = (r_state == ST_MEM);
  assign w_in_wb    = (r_state == ST_WB);
  assign w_ready    = (w_in_fetch & i_imem_ready) | (w_in_mem & i_dmem_ready);
  assign w_waiting  = (w_in_fetch | w_in_mem) & ~w_ready;
  // Ready in the same cycle the count would hit TIMEOUT wins over the error.
  assign w_expired  = TMO_EN & w_waiting & (r_wait == WAIT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FETCH:  if (i_imem_ready) w_state_nxt = ST_DECODE;
                 else if (w_expired) w_state_nxt = ST_HALT;
      ST_DECODE: w_state_nxt = w_dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC:   w_state_nxt = cls_bit(CLS_MEM, r_cls) ? ST_MEM : ST_WB;
      ST_MEM:    if (i_dmem_ready) w_state_nxt = ST_WB;
                 else if (w_expired) w_state_nxt = ST_HALT;
      ST_WB:     w_state_nxt = ST_FETCH;
      default:   w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_FETCH;
      r_cls     <= CLS_ILLEGAL;
      r_wait    <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= (TMO_EN && w_waiting) ? r_wait + 1'b1 : '0;
      if (r_state == ST_DECODE) begin
        r_cls <= w_dec_cls;
        if (w_dec_illegal) r_illegal <= 1'b1;
      end
      if (w_expired) r_bus_err <= 1'b1;
      if (w_in_wb)   r_instret <= r_instret + 1'b1;
    end
  end

  // Strobes are forced low while reset is held, whatever state is still latched.
  assign w_live      = ~i_rst;
  assign o_imem_req  = w_live & w_in_fetch;
  assign o_ir_w_en   = w_live & w_in_fetch & i_imem_ready;
  assign o_dmem_req  = w_live & w_in_mem;
  assign o_dmem_w_en = o_dmem_req & (r_cls == CLS_STORE);
  assign o_pc_w_en   = w_live & w_in_wb;
  assign o_reg_w_en  = o_pc_w_en & cls_bit(CLS_REG_WE, r_cls);
  assign o_pc_sel    = o_pc_w_en &
                       (cls_bit(CLS_JUMP, r_cls) | ((r_cls == CLS_BRANCH) & i_branch_taken));

  assign o_illegal = r_illegal;
  assign o_bus_err = r_bus_err;
  assign o_instret = r_instret;
  assign o_state   = r_state;

  a_one_req: assert property (@(posedge i_clk) !(o_imem_req && o_dmem_req));

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
- Multi-cycle control FSM for core_v1.
- Sequences fetch, decode, execute, memory and writeback over the existing single-cycle datapath and decode.
- Owns the instruction and data memory request/ready handshakes and gates all architectural write enables (IR, PC, register file, dmem).
- Maintains a retired-instruction counter and sticky illegal-opcode and bus-timeout flags.

Parameters:
- TIMEOUT, 16: max cycles a memory request waits for ready; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- opcode  in  7  instruction register bits [6:0]
- branch_taken  in  1  branch compare result from ALU, valid in EXEC/WB
- imem_ready  in  1  instruction memory has data for the current request
- dmem_ready  in  1  data memory completed the current access
- imem_req  out  1  instruction fetch request
- ir_w_en  out  1  latch fetched word into instruction register
- dmem_req  out  1  data access request
- dmem_w_en  out  1  data access is a store (valid only with dmem_req)
- reg_w_en  out  1  register file write strobe
- pc_w_en  out  1  PC update strobe
- pc_sel  out  1  0: pc+4, 1: branch/jump target
- illegal  out  1  sticky: unsupported opcode decoded
- bus_err  out  1  sticky: memory timeout
- instret  out  CNT_W  retired instruction count
- state  out  3  current FSM state, for debug

Interface decision: one clock, clk; rst is synchronous and active-high.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Reset: on any rising edge with rst=1:
  - state=FETCH, instret=0, illegal=0, bus_err=0.
  - All strobes and requests are 0 during reset.
  - Reset mid-access abandons the transaction; a late ready is ignored.
- Outputs are Moore from state plus registered class, except ir_w_en, which is combinational: FETCH & imem_ready.
- FETCH:
  - imem_req=1, held until imem_ready. Ready in the first FETCH cycle is accepted.
  - On ready: ir_w_en=1 for exactly that cycle; next state DECODE.
- DECODE: classify opcode and register the class for use in later states.
  - Supported opcodes: 0000011 load, 0100011 store, 0110011 op, 0010011 op-imm, 1100011 branch, 0110111 lui, 0010111 auipc, 1101111 jal, 1100111 jalr.
  - Any other opcode: set illegal=1, go to HALT.
  - Otherwise go to EXEC.
- EXEC: one cycle. Load/store go to MEM; all other classes go to WB.
- MEM:
  - dmem_req=1; dmem_w_en=1 for store, 0 for load.
  - Wait for dmem_ready, then go to WB.
- WB: one cycle.
  - pc_w_en=1.
  - reg_w_en=1 for load, op, op-imm, lui, auipc, jal, jalr; 0 for store and branch.
  - pc_sel=1 for jal/jalr, =branch_taken for branch, else 0.
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state FETCH.
- HALT: absorbing. No requests or strobes are issued; only rst exits.
- Timeout:
  - A wait counter clears on entering FETCH or MEM and increments each cycle the request is unanswered.
  - When TIMEOUT!=0 and the count reaches TIMEOUT without ready: bus_err=1, go to HALT.
  - Ready arriving in the same cycle the count reaches TIMEOUT wins: no error.
- imem_ready and dmem_ready are ignored outside FETCH and MEM respectively.
- Latency with zero-wait memory:
  - ALU, branch, lui, auipc, jal, jalr: 4 cycles.
  - Load and store: 5 cycles.
  - Each wait cycle adds 1.
- Invariant: at most one of imem_req and dmem_req is high in any cycle.

Decomposition:
- Shared package core_pkg holds:
  - Opcode localparams.
  - State encoding.
  - Instruction-class enum: LOAD, STORE, OP, OPIMM, BRANCH, LUI, AUIPC, JAL, JALR, ILLEGAL.
  - Write-enables-per-class constants.
- Sub-module: opcode_classifier, combinational, mapping opcode to class and illegal. It is reused by the main decode.

Test Plan:
- add (0110011), imem_ready in first FETCH cycle -> states 0,1,2,4,0. reg_w_en=1, pc_w_en=1, pc_sel=0 in WB. instret 0->1.
- sw (0100011), dmem_ready after 2 wait cycles -> dmem_req high 3 cycles with dmem_w_en=1. reg_w_en=0 in WB. Total 7 cycles.
- beq with branch_taken=1, then =0 -> pc_sel=1 then 0 in the respective WB cycles. reg_w_en=0 both times.
- opcode 7'b1111111 -> illegal=1 after DECODE, state=5 thereafter. No requests for 20 cycles. rst clears illegal and returns to FETCH.
- TIMEOUT=4, imem_ready never asserted -> bus_err=1 after 4 FETCH cycles, state=5. Repeat with ready on the 4th cycle -> no error.
- rst asserted in MEM with dmem_req=1 -> next cycle state=0, dmem_req=0, instret=0. dmem_ready pulsed after reset is ignored.
